// File: rtl/prog_clk_divider.sv
// Programmable clock divider: divides clk by a runtime-writable ratio N.
// Ratio changes made while running take effect only at a period boundary, so no period is ever cut short or stretched.
module prog_clk_divider #(
  parameter int W         = 8,
  parameter int RST_RATIO = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         ratio_wr,
  input  logic [W-1:0] ratio_in,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] ratio_cur,
  output logic         pending,
  output logic         err
);

  localparam logic [W-1:0] RST_VAL = W'(RST_RATIO);

  logic [W-1:0] cnt_r;
  logic [W-1:0] shadow_r;
  logic         run_r;

  logic         wr_ok_s;
  logic         wr_bad_s;
  logic         wrap_s;
  logic         start_s;
  logic [W-1:0] next_ratio_s;
  logic [W-1:0] next_cnt_s;

  // High phase length ceil(n/2). It cannot overflow because n is at most 2^W-1.
  function automatic logic [W-1:0] high_len(input logic [W-1:0] n);
    return (n >> 1) + {{(W-1){1'b0}}, n[0]};
  endfunction

  // Write qualification and next-period decode
  always_comb begin
    wr_ok_s      = ratio_wr && (ratio_in != '0);
    wr_bad_s     = ratio_wr && (ratio_in == '0);
    wrap_s       = (cnt_r == (ratio_cur - W'(1)));
    start_s      = !run_r || wrap_s;
    next_ratio_s = pending ? shadow_r : ratio_cur;
    next_cnt_s   = start_s ? '0 : (cnt_r + W'(1));
  end

  // Counter, ratio/shadow handling and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r     <= '0;
      shadow_r  <= RST_VAL;
      run_r     <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      ratio_cur <= RST_VAL;
      pending   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= wr_bad_s;
      if (!en) begin
        run_r   <= 1'b0;
        cnt_r   <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (wr_ok_s) begin
          ratio_cur <= ratio_in;
          shadow_r  <= ratio_in;
          pending   <= 1'b0;
        end else begin
          pending <= pending;
        end
      end else begin
        run_r <= 1'b1;
        cnt_r <= next_cnt_s;
        tick  <= start_s;
        if (start_s) begin
          clk_out   <= 1'b1;
          ratio_cur <= next_ratio_s;
        end else begin
          clk_out <= (next_cnt_s < high_len(ratio_cur));
        end
        // A write on a boundary edge arms the following boundary, not this one
        if (wr_ok_s) begin
          shadow_r <= ratio_in;
          pending  <= 1'b1;
        end else if (start_s) begin
          pending <= 1'b0;
        end else begin
          pending <= pending;
        end
      end
    end
  end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 The block SHALL have parameter W, default 8: width of the divide ratio.
REQ-002 The block SHALL have parameter RST_RATIO, default 2: ratio loaded at reset; legal range 1..2^W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: divider enable.
REQ-006 The block SHALL have port ratio_wr, input, 1 bit: one-cycle write strobe for ratio_in.
REQ-007 The block SHALL have port ratio_in, input, W bits: requested divide ratio N.
REQ-008 The block SHALL have port clk_out, output, 1 bit: registered divided clock.
REQ-009 The block SHALL have port tick, output, 1 bit: one-cycle pulse marking each period start.
REQ-010 The block SHALL have port ratio_cur, output, W bits: ratio currently in effect.
REQ-011 The block SHALL have port pending, output, 1 bit: a written ratio is waiting for a period boundary.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected write.

Function
REQ-013 A period of ratio N SHALL span N clk cycles: clk_out high for ceil(N/2) cycles, then low for floor(N/2) cycles (even N gives 50% duty, odd N gives one extra high cycle).
REQ-014 tick SHALL be high exactly in the first cycle of each period, coincident with the clk_out high phase start.
REQ-015 The internal counter SHALL count 0..N-1 and wrap to 0; each wrap is a period boundary.
REQ-016 N=1 SHALL give clk_out constantly 1 and tick constantly 1 while enabled.
REQ-017 Latency: on the first rising edge sampling en=1 after en=0 or reset, clk_out and tick SHALL go to 1 (first cycle of the first period).
REQ-018 On an edge sampling en=0, counter SHALL clear to 0, clk_out and tick SHALL go to 0, and the period SHALL restart fresh on re-enable.
REQ-019 A write with ratio_in=0 SHALL be rejected: err pulses 1 on the next cycle, ratio_cur, shadow and pending unchanged.
REQ-020 A legal write while en=0 SHALL update ratio_cur on the same edge and leave pending=0.
REQ-021 A legal write while en=1 SHALL load a shadow register and set pending=1; ratio_cur SHALL be unchanged until the next period boundary.
REQ-022 At a period boundary with pending=1, ratio_cur SHALL take the shadow value, pending SHALL clear, and the new period SHALL use the new ratio (no truncated or stretched period, no glitch on clk_out).
REQ-023 A write sampled on the same edge as a boundary SHALL be applied at the following boundary, not the current one.
REQ-024 Multiple writes before a boundary SHALL be last-write-wins.
REQ-025 A write on the edge that also samples en 1->0 SHALL be treated as an en=0 write (immediate, pending cleared).
REQ-026 All outputs SHALL be driven directly from flops.

Reset
REQ-027 While rstn=0, the block SHALL hold: counter=0, clk_out=0, tick=0, err=0, pending=0, ratio_cur=RST_RATIO, shadow=RST_RATIO.
REQ-028 Reset assertion mid-period SHALL force these values immediately, without waiting for clk.
REQ-029 Operation SHALL resume per REQ-017 on the first edge after rstn release where en=1.

Verification
REQ-030 Reset then en=1, default ratio 2 -> clk_out 1,0,1,0...; tick 1,0,1,0...; ratio_cur=2.
REQ-031 en=0, write 10, en=1 -> clk_out 5 cycles high, 5 low, repeated; tick every 10th cycle; write 5 -> 3 high, 2 low.
REQ-032 Ratio 4 running, write 6 in cycle 2 of a period -> pending=1; current period completes as 4; next period 3 high/3 low; pending clears at the boundary.
REQ-033 Write 0 while running -> err pulse 1 cycle; output and ratio_cur unchanged; write 1 -> after boundary, clk_out and tick stuck high.
REQ-034 rstn pulled low mid-period, ratio 7 and pending=1 -> outputs zero immediately; after release, ratio_cur=2 and pending=0.
REQ-035 Back-to-back writes 3 then 8 within one period -> only 8 is applied at the next boundary; no period of 3 ever appears.
